// File: rtl/unpack_arbiter_if.sv
// Requester-side and gearbox-side signal bundle of unpack_arbiter.
// The slave modport is the arbiter; the master modport is the requester/gearbox side.
interface unpack_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int IN_WIDTH = 32
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*IN_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]          req_last;
  logic [N_REQ-1:0]          req_ready;
  logic                      gb_valid_in;
  logic [IN_WIDTH-1:0]       gb_data_in;
  logic                      gb_flush;
  logic [GW-1:0]             grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, gb_valid_in, gb_data_in, gb_flush, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, gb_valid_in, gb_data_in, gb_flush, grant_id, busy
  );
endinterface

// File: rtl/unpack_arbiter.sv
// Round-robin packet arbiter and occupancy-based flow control in front of a 32-to-7 unpack gearbox.
// Optional residual flush at packet end is enabled by defining UNPACK_ARB_FLUSH_EN.
module unpack_arbiter #(
  parameter int N_REQ     = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 7
) (
  input  logic              clk,
  input  logic              rst,
  unpack_arbiter_if.slave   bus
);
  localparam int OCC_W = $clog2(IN_WIDTH + OUT_WIDTH);
  localparam int GW    = $clog2(N_REQ);
  localparam logic [OCC_W-1:0] OUT_W_C = OCC_W'(OUT_WIDTH);
  localparam logic [OCC_W-1:0] IN_W_C  = OCC_W'(IN_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t           state;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_after;
  logic [GW-1:0]    rr;
  logic [GW-1:0]    grant_id;
  logic [GW-1:0]    pick;
  logic [GW-1:0]    idx;
  logic             pick_ok;
  logic             emit;
  logic             can_accept;
  logic             in_xfer;
  logic             fire;

  // Gearbox occupancy after this cycle's emit, and whether a whole word still fits.
  always_comb begin
    emit       = (occ >= OUT_W_C);
    occ_after  = emit ? (occ - OUT_W_C) : occ;
    can_accept = (occ_after <= OUT_W_C);
  end

  assign in_xfer = (state == XFER);
  assign fire    = in_xfer & bus.req_valid[grant_id] & can_accept;

  // Descending scan so the last hit is the first valid index at or after rr.
  always_comb begin
    pick    = '0;
    idx     = '0;
    pick_ok = |bus.req_valid;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx  = GW'((int'(rr) + k) % N_REQ);
      pick = bus.req_valid[idx] ? idx : pick;
    end
  end

  // Only the granted requester may see ready, and only while the gearbox can absorb a word.
  always_comb begin
    bus.req_ready  = '0;
    bus.gb_data_in = '0;
    if (in_xfer) begin
      bus.req_ready[grant_id] = can_accept;
      bus.gb_data_in          = bus.req_data[int'(grant_id)*IN_WIDTH +: IN_WIDTH];
    end else begin
      bus.req_ready  = '0;
      bus.gb_data_in = '0;
    end
  end

  assign bus.gb_valid_in = fire;
  assign bus.grant_id    = grant_id;
  assign bus.busy        = (state != IDLE);
`ifdef UNPACK_ARB_FLUSH_EN
  assign bus.gb_flush    = (state == FLUSH);
`else
  assign bus.gb_flush    = 1'b0;
`endif

  // Arbitration state, grant, round-robin pointer and modelled gearbox occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= '0;
      occ      <= '0;
      grant_id <= '0;
    end else begin
      occ <= occ_after + (fire ? IN_W_C : {OCC_W{1'b0}});
      case (state)
        IDLE: begin
          if (pick_ok) begin
            grant_id <= pick;
            rr       <= GW'((int'(pick) + 1) % N_REQ);
            state    <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (fire && bus.req_last[grant_id]) begin
            state <= DRAIN;
          end else begin
            state <= XFER;
          end
        end
        DRAIN: begin
          if (occ < OUT_W_C) begin
`ifdef UNPACK_ARB_FLUSH_EN
            state <= (occ != '0) ? FLUSH : IDLE;
`else
            state <= IDLE;
`endif
          end else begin
            state <= DRAIN;
          end
        end
        FLUSH: begin
          occ   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unpack_arbiter.sv
// Self-checking bench for unpack_arbiter: directed scenarios plus randomized packets
// compared cycle by cycle against a packet-level occupancy/round-robin reference model.
module tb_unpack_arbiter;
  localparam int N     = 4;
  localparam int W     = 32;
  localparam int OW    = 7;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unpack_arbiter_if #(.N_REQ(N), .IN_WIDTH(W)) bus ();
  unpack_arbiter #(.N_REQ(N), .IN_WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-requester word queues: last flag and data per entry.
  bit             lbuf [N][DEPTH];
  logic [W-1:0]   dbuf [N][DEPTH];
  int             head [N];
  int             tail [N];
  int             hold [N];
  int             bubble [N];
  int             gap_pct;

  // Reference model: who owns the gearbox, whether it drains/flushes, bits held.
  int m_occ, m_owner, m_rr, m_gid;
  bit m_drain, m_flush;

  int grants_q[$], grant_cyc_q[$], fire_pre_q[$], fire_post_q[$], fire_cyc_q[$];
  int cyc_n, flush_cnt, foreign_ready;

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_occ = 0; m_owner = -1; m_rr = 0; m_gid = 0; m_drain = 1'b0; m_flush = 1'b0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; hold[i] = 0; bubble[i] = 0;
    end
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
  endtask

  task automatic clear_logs();
    grants_q.delete(); grant_cyc_q.delete(); fire_pre_q.delete();
    fire_post_q.delete(); fire_cyc_q.delete();
    cyc_n = 0; flush_cnt = 0; foreign_ready = 0;
  endtask

  task automatic push_word(input int i, input bit last, input logic [W-1:0] d);
    lbuf[i][tail[i]] = last;
    dbuf[i][tail[i]] = d;
    tail[i]++;
  endtask

  task automatic push_pkt(input int i, input int len);
    for (int w = 0; w < len; w++) push_word(i, (w == len - 1), W'($urandom));
  endtask

  // One clock: drive at negedge, check #1 later, advance the model at posedge.
  task automatic cycle();
    logic [N-1:0]   vld, lst, one_hot, exp_rdy;
    logic [N*W-1:0] dat;
    logic [W-1:0]   exp_dat;
    bit emit, can, xfer, fire;
    int after, f_owner;
    vld = '0; lst = '0; dat = '0;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        vld[i] = (hold[i] == 0) && ($urandom_range(0, 99) >= gap_pct);
        lst[i] = lbuf[i][head[i]];
        dat[i*W +: W] = dbuf[i][head[i]];
      end
    end
    bus.req_valid = vld; bus.req_last = lst; bus.req_data = dat;
    #1;
    emit  = (m_occ >= OW);
    after = emit ? m_occ - OW : m_occ;
    can   = (after <= OW);
    xfer  = (m_owner >= 0) && !m_drain;
    exp_rdy = '0; exp_dat = '0; fire = 1'b0; one_hot = '0; f_owner = m_owner;
    if (xfer) begin
      exp_rdy[m_owner] = can;
      one_hot[m_owner] = 1'b1;
      exp_dat = dat[m_owner*W +: W];
      fire = vld[m_owner] && can;
      if ((bus.req_ready & ~one_hot) != '0) foreign_ready++;
    end
    check_val("req_ready", bus.req_ready, exp_rdy);
    check_val("gb_valid_in", bus.gb_valid_in, fire);
    check_val("gb_data_in", bus.gb_data_in, exp_dat);
    check_val("gb_flush", bus.gb_flush, m_flush);
    check_val("grant_id", bus.grant_id, m_gid);
    check_val("busy", bus.busy, (m_owner >= 0) || m_drain || m_flush);
    check_val("occ", dut.occ, m_occ);
    if (bus.gb_flush) flush_cnt++;
    @(posedge clk);
    if (m_flush) begin
      m_occ = 0; m_flush = 1'b0;
    end else begin
      if (m_drain) begin
        if (m_occ < OW) begin
          m_drain = 1'b0; m_owner = -1;
`ifdef UNPACK_ARB_FLUSH_EN
          m_flush = (m_occ != 0);
`endif
        end
      end else if (m_owner >= 0) begin
        if (fire && lst[m_owner]) m_drain = 1'b1;
      end else if (vld != '0) begin
        int found = -1;
        for (int k = 0; k < N; k++) begin
          int idx = (m_rr + k) % N;
          if (found < 0 && vld[idx]) found = idx;
        end
        m_owner = found; m_gid = found; m_rr = (found + 1) % N;
        grants_q.push_back(found); grant_cyc_q.push_back(cyc_n);
      end
      if (fire) fire_pre_q.push_back(m_occ);
      m_occ = after + (fire ? W : 0);
      if (fire) begin
        fire_post_q.push_back(m_occ); fire_cyc_q.push_back(cyc_n);
      end
    end
    for (int i = 0; i < N; i++) if (hold[i] > 0) hold[i]--;
    if (fire) begin
      head[f_owner]++;
      if (!lst[f_owner]) hold[f_owner] = bubble[f_owner];
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int maxc);
    int n = 0;
    while ((pending() || m_owner >= 0 || m_drain || m_flush) && n < maxc) begin
      cycle();
      n++;
    end
    if (n >= maxc) check_val("timeout", n, 0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_reset();
    clear_stim();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_rr[5];
    int n;
    exp_rr = '{0, 1, 2, 3, 0};
    gap_pct = 0;
    rst = 1'b0;
    model_reset();
    clear_stim();
    clear_logs();
    #1 rst = 1'b1;
    #2;
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_ready", bus.req_ready, 0);
    check_val("rst_valid_in", bus.gb_valid_in, 0);
    check_val("rst_flush", bus.gb_flush, 0);
    check_val("rst_data", bus.gb_data_in, 0);
    check_val("rst_grant", bus.grant_id, 0);
    check_val("rst_occ", dut.occ, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single 2-word packet from requester 0.
    push_word(0, 1'b0, 32'h1234_5678);
    push_word(0, 1'b1, 32'hCAFE_F00D);
    run_until_idle(200);
    check_val("sp_grant", qget(grants_q, 0), 0);
    check_val("sp_grant_cyc", qget(grant_cyc_q, 0), 0);
    check_val("sp_fires", fire_pre_q.size(), 2);
    check_val("sp_occ_at_2nd", qget(fire_pre_q, 1), 11);
    check_val("sp_occ_after_2nd", qget(fire_post_q, 1), 36);
    check_val("sp_busy_end", bus.busy, 0);

    // Round robin: all four requesters valid, requester 0 has two 1-word packets.
    reset_pulse(); clear_logs();
    push_word(0, 1'b1, W'($urandom));
    push_word(0, 1'b1, W'($urandom));
    for (int i = 1; i < N; i++) push_word(i, 1'b1, W'($urandom));
    run_until_idle(400);
    check_val("rr_count", grants_q.size(), 5);
    for (int k = 0; k < 5; k++) check_val("rr_order", qget(grants_q, k), exp_rr[k]);

    // All-ones word: residual of 4 bits either flushed or carried.
    reset_pulse(); clear_logs();
    push_word(1, 1'b1, 32'hFFFF_FFFF);
    run_until_idle(200);
`ifdef UNPACK_ARB_FLUSH_EN
    check_val("fl_pulses", flush_cnt, 1);
    check_val("fl_occ_end", dut.occ, 0);
`else
    check_val("fl_pulses", flush_cnt, 0);
    check_val("fl_occ_end", dut.occ, 4);
`endif
    clear_logs();
    push_word(2, 1'b1, W'($urandom));
    run_until_idle(200);
    check_val("fl_next_fire_cyc", qget(fire_cyc_q, 0), 1);
`ifdef UNPACK_ARB_FLUSH_EN
    check_val("fl_next_occ", qget(fire_post_q, 0), 32);
`else
    check_val("fl_next_occ", qget(fire_post_q, 0), 36);
`endif

    // Mid-packet bubble on requester 2 while 0 and 3 wait.
    clear_logs();
    push_word(1, 1'b1, W'($urandom));
    run_until_idle(200);
    clear_logs();
    bubble[2] = 3;
    push_word(2, 1'b0, W'($urandom));
    push_word(2, 1'b1, W'($urandom));
    push_word(0, 1'b1, W'($urandom));
    push_word(3, 1'b1, W'($urandom));
    run_until_idle(400);
    check_val("bub_first", qget(grants_q, 0), 2);
    check_val("bub_second", qget(grants_q, 1), 3);
    check_val("bub_foreign_ready", foreign_ready, 0);
    bubble[2] = 0;

    // Asynchronous reset in XFER while occ=25.
    clear_logs();
    push_word(1, 1'b0, W'($urandom));
    push_word(1, 1'b0, W'($urandom));
    push_word(1, 1'b1, W'($urandom));
    n = 0;
    while (!(m_occ == 25 && m_owner >= 0 && !m_drain) && n < 50) begin
      cycle();
      n++;
    end
    check_val("ar_reach_occ25", dut.occ, 25);
    #2 rst = 1'b1;
    #1;
    check_val("ar_busy", bus.busy, 0);
    check_val("ar_ready", bus.req_ready, 0);
    check_val("ar_valid_in", bus.gb_valid_in, 0);
    check_val("ar_data", bus.gb_data_in, 0);
    check_val("ar_flush", bus.gb_flush, 0);
    check_val("ar_grant", bus.grant_id, 0);
    check_val("ar_occ", dut.occ, 0);
    model_reset();
    clear_stim();
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    push_word(0, 1'b1, W'($urandom));
    push_word(3, 1'b1, W'($urandom));
    run_until_idle(200);
    check_val("ar_regrant", qget(grants_q, 0), 0);

    // Randomized packets with random valid gaps and bubbles.
    clear_logs();
    gap_pct = 30;
    for (int i = 0; i < N; i++) begin
      bubble[i] = $urandom_range(0, 2);
      for (int p = 0; p < 6; p++) push_pkt(i, $urandom_range(1, 4));
    end
    run_until_idle(5000);
    check_val("rnd_packets", grants_q.size(), 6 * N);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
